// File: rtl/seq_detect_rr_sched.sv
// Round-robin scheduler that time-shares one serial pattern detector among NCH
// request/grant channels, saving each channel's shift history and fill count.
module seq_detect_rr_sched #(
  parameter int                 NCH     = 4,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PAT     = 4'b1001,
  parameter int                 HIT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NCH-1:0]           req,
  input  logic [NCH-1:0]           bit_i,
  input  logic [NCH-1:0]           clr,
  output logic [NCH-1:0]           gnt,
  output logic                     out,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic [HIT_W-1:0]         hits
);

  localparam int PW = $clog2(NCH);
  localparam int CW = $clog2(PAT_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(PAT_LEN - 1);

  logic [PW-1:0]      ptr_q;
  logic [PAT_LEN-2:0] hist_q [NCH];
  logic [CW-1:0]      cnt_q  [NCH];
  logic               out_q;
  logic [PW-1:0]      outCh_q;
  logic [HIT_W-1:0]   hits_q;

  logic [PW-1:0]      ptrEff;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      gntIdx;
  logic               gntAny;
  logic [NCH-1:0]     elig;
  logic               gntBit;
  logic [PAT_LEN-1:0] window_d;
  logic               match_d;

  // Unused pointer encodings collapse onto the last channel.
  always_comb begin
    ptrEff = ptr_q;
    if (int'(ptr_q) > NCH - 1) ptrEff = PW'(NCH - 1);
  end

  assign elig = en ? (req & ~clr) : '0;

  always_comb begin
    gnt    = '0;
    gntIdx = '0;
    gntAny = 1'b0;
    cand   = ptrEff;
    for (int i = 0; i < NCH; i++) begin
      if (int'(cand) >= NCH - 1) cand = '0;
      else                       cand = cand + PW'(1);
      if (!gntAny && elig[cand]) begin
        gntAny      = 1'b1;
        gntIdx      = cand;
        gnt[cand]   = 1'b1;
      end
    end
  end

  assign gntBit   = bit_i[gntIdx];
  assign window_d = {hist_q[gntIdx], gntBit};
  assign match_d  = gntAny && (cnt_q[gntIdx] == CNT_MAX) && (window_d == PAT);

  // A flush on a channel always takes priority; it can never coincide with its grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= PW'(NCH - 1);
      out_q   <= 1'b0;
      outCh_q <= '0;
      hits_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        hist_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      out_q <= match_d;
      if (match_d) begin
        outCh_q <= gntIdx;
        hits_q  <= hits_q + HIT_W'(1);
      end
      if (gntAny) ptr_q <= gntIdx;
      for (int c = 0; c < NCH; c++) begin
        if (clr[c]) begin
          hist_q[c] <= '0;
          cnt_q[c]  <= '0;
        end else if (gntAny && (gntIdx == PW'(c))) begin
          hist_q[c] <= window_d[PAT_LEN-2:0];
          if (cnt_q[c] != CNT_MAX) cnt_q[c] <= cnt_q[c] + CW'(1);
        end
      end
    end
  end

  assign out    = out_q;
  assign out_ch = outCh_q;
  assign hits   = hits_q;

endmodule

// File: tb/tb_seq_detect_rr_sched.sv
// Scoreboard bench: requesters replay per-channel bit scripts, a queue-based
// model predicts grants and match outputs, and a monitor checks every output cycle.
module tb_seq_detect_rr_sched;

  localparam int       NCH     = 4;
  localparam int       PAT_LEN = 4;
  localparam int       HIT_W   = 16;
  localparam bit [3:0] PAT     = 4'b1001;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [NCH-1:0] req;
  logic [NCH-1:0] bitIn;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] gnt;
  logic           out;
  logic [1:0]     outCh;
  logic [15:0]    hits;

  always #5 clk = ~clk;

  seq_detect_rr_sched #(
    .NCH(NCH), .PAT_LEN(PAT_LEN), .PAT(PAT), .HIT_W(HIT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .bit_i(bitIn), .clr(clr),
    .gnt(gnt), .out(out), .out_ch(outCh), .hits(hits)
  );

  typedef struct packed {
    logic        out;
    logic [1:0]  ch;
    logic [15:0] hits;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passed = 0;

  bit pend[NCH];
  bit pendBit[NCH];
  bit scriptQ[NCH][$];
  bit chBits[NCH][$];
  int modelPtr;
  int modelHits;
  int modelCh;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // A channel matches when its last PAT_LEN bits since the last flush spell PAT.
  function automatic bit modelMatch(input int c);
    int v;
    v = 0;
    if (chBits[c].size() != PAT_LEN) return 1'b0;
    for (int k = 0; k < PAT_LEN; k++) v = (v << 1) | int'(chBits[c][k]);
    return v == int'(PAT);
  endfunction

  function automatic bit busy();
    bit b;
    b = 1'b0;
    for (int c = 0; c < NCH; c++) if (pend[c] || scriptQ[c].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic applyStimulus(input bit enV, input logic [NCH-1:0] clrV);
    logic [NCH-1:0] elig;
    logic [NCH-1:0] expGnt;
    int             gi;
    int             idx;
    exp_t           e;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (!pend[c] && scriptQ[c].size() > 0) begin
        pendBit[c] = scriptQ[c].pop_front();
        pend[c]    = 1'b1;
      end
      req[c]   = pend[c];
      bitIn[c] = pend[c] ? pendBit[c] : 1'($urandom_range(0, 1));
    end
    en  = enV;
    clr = clrV;
    #1;
    elig   = enV ? (req & ~clrV) : '0;
    gi     = -1;
    expGnt = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (modelPtr + i) % NCH;
      if (gi < 0 && elig[idx]) gi = idx;
    end
    if (gi >= 0) expGnt[gi] = 1'b1;
    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    for (int c = 0; c < NCH; c++) if (clrV[c]) chBits[c].delete();
    e.out = 1'b0;
    if (gi >= 0) begin
      chBits[gi].push_back(pendBit[gi]);
      if (chBits[gi].size() > PAT_LEN) void'(chBits[gi].pop_front());
      if (modelMatch(gi)) begin
        e.out     = 1'b1;
        modelHits = (modelHits + 1) % (1 << HIT_W);
        modelCh   = gi;
      end
      modelPtr = gi;
      pend[gi] = 1'b0;
    end
    e.ch   = 2'(modelCh);
    e.hits = 16'(modelHits);
    expQ.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    clr = '0;
    en  = 1'b0;
    #1;
    checkOutput("rstOut", 32'(out), 32'd0);
    checkOutput("rstHits", 32'(hits), 32'd0);
    checkOutput("rstOutCh", 32'(outCh), 32'd0);
    modelPtr  = NCH - 1;
    modelHits = 0;
    modelCh   = 0;
    for (int c = 0; c < NCH; c++) begin
      chBits[c].delete();
      scriptQ[c].delete();
      pend[c] = 1'b0;
    end
    expQ.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input bit enV, input int maxCycles);
    int n;
    n = 0;
    while (busy() && n < maxCycles) begin
      applyStimulus(enV, '0);
      n++;
    end
    checkOutput("drained", 32'(busy()), 32'd0);
    applyStimulus(1'b1, '0);
  endtask

  task automatic pushBits(input int c, input bit [7:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) scriptQ[c].push_back(bits[k]);
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("out", 32'(out), 32'(e.out));
        checkOutput("outCh", 32'(outCh), 32'(e.ch));
        checkOutput("hits", 32'(hits), 32'(e.hits));
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; req = '0; bitIn = '0; clr = '0;
    doReset();

    pushBits(0, 8'b1001001, 7);
    drain(1'b1, 40);
    checkOutput("t1Hits", 32'(hits), 32'd2);
    checkOutput("t1Ch", 32'(outCh), 32'd0);

    doReset();
    for (int c = 0; c < NCH; c++) pushBits(c, 8'($urandom), 8);
    drain(1'b1, 100);

    doReset();
    pushBits(1, 8'b1001, 4);
    pushBits(2, 8'b1001, 4);
    drain(1'b1, 40);
    checkOutput("t3Hits", 32'(hits), 32'd2);
    checkOutput("t3Ch", 32'(outCh), 32'd2);

    doReset();
    pushBits(0, 8'b100, 3);
    drain(1'b1, 20);
    pushBits(0, 8'b1, 1);
    applyStimulus(1'b1, 4'b0001);
    pushBits(0, 8'b0011001, 7);
    drain(1'b1, 40);
    checkOutput("t4Hits", 32'(hits), 32'd2);

    doReset();
    pushBits(3, 8'b100, 3);
    drain(1'b1, 20);
    doReset();
    pushBits(0, 8'b1, 1);
    pushBits(3, 8'b1, 1);
    drain(1'b1, 20);
    checkOutput("t5Hits", 32'(hits), 32'd0);

    doReset();
    for (int c = 0; c < NCH; c++) pushBits(c, 8'b100, 3);
    drain(1'b1, 40);
    for (int c = 0; c < NCH; c++) pushBits(c, 8'b1, 1);
    repeat (5) applyStimulus(1'b0, '0);
    drain(1'b1, 40);
    checkOutput("t6Hits", 32'(hits), 32'd4);

    doReset();
    for (int i = 0; i < 1500; i++) begin
      logic [NCH-1:0] clrV;
      if (i == 700) doReset();
      for (int c = 0; c < NCH; c++) begin
        if (scriptQ[c].size() == 0 && $urandom_range(0, 1) == 1)
          scriptQ[c].push_back(1'($urandom_range(0, 1)));
        clrV[c] = ($urandom_range(0, 19) == 0);
      end
      applyStimulus($urandom_range(0, 9) != 0, clrV);
    end
    drain(1'b1, 100);
    repeat (2) @(negedge clk);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
